// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
// Machine-mode trap sequencer between the pipeline controller and fetch.
// Takes the prioritised exception report, machine interrupt lines and mret,
// owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval) and
// requests a PC redirect plus full pipeline flush from fetch through a
// ready/valid handshake.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   en_exception_i, exception_*   exception report (cause code, PC, address)
//   mret_i                        mret retiring this cycle
//   interrupt_pc_i                mepc value used when an interrupt is taken
//   interrupt_accept_i            pipeline is at an interruptible boundary
//   irq_software/timer/external_i level-sensitive machine interrupt lines
//   csr_addr_i/we_i/wdata_i       CSR access; csr_rdata_o is combinational
//   redirect_valid_o/pc_o/ready_i redirect handshake with fetch
//   flush_all_o                   flush fetch, decode and execute
//   trap_busy_o                   controller busy, upstream holds exceptions
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_exception_i,
    input  logic [2:0]      exception_cause_i,
    input  logic [XLEN-1:0] exception_program_counter_i,
    input  logic [XLEN-1:0] exception_adress_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] interrupt_pc_i,
    input  logic            interrupt_accept_i,
    input  logic            irq_software_i,
    input  logic            irq_timer_i,
    input  logic            irq_external_i,
    input  logic [11:0]     csr_addr_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_all_o,
    output logic            trap_busy_o
);

    // Exception cause codes as reported by the pipeline controller
    localparam logic [2:0] EXCEP_INSTR_MISALIGNED        = 3'd0;
    localparam logic [2:0] EXCEP_ILLEGAL_INSTRUCTION     = 3'd1;
    localparam logic [2:0] EXCEP_BREAKPOINT              = 3'd2;
    localparam logic [2:0] EXCEP_LOAD_ADRESS_MISALIGNED  = 3'd3;
    localparam logic [2:0] EXCEP_STORE_ADRESS_MISALIGNED = 3'd4;
    localparam logic [2:0] EXCEP_ENV_CALL                = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Only the three machine interrupt enable bits exist in mie
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t      state_r;
    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic [31:0] mie_csr_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [31:0] mtval_r;
    logic [31:0] target_r;
    logic        redirect_valid_r;
    logic        flush_all_r;
    logic        trap_busy_r;

    logic [31:0] mip_s;
    logic [31:0] pend_s;
    logic        int_take_s;
    logic [4:0]  int_id_s;
    logic [31:0] mtvec_base_s;
    logic [31:0] int_target_s;
    logic [3:0]  exc_code_s;
    logic [31:0] mstatus_s;

    assign mip_s        = {20'd0, irq_external_i, 3'd0, irq_timer_i, 3'd0, irq_software_i, 3'd0};
    assign pend_s       = mip_s & mie_csr_r;
    assign int_take_s   = interrupt_accept_i & mstatus_mie_r & (|pend_s);
    assign mtvec_base_s = {mtvec_r[31:2], 2'b00};
    // MPP is hardwired to machine mode
    assign mstatus_s    = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};

    // Highest-priority pending interrupt: external > software > timer
    always_comb begin
        int_id_s = 5'd0;
        if (pend_s[11]) begin
            int_id_s = 5'd11;
        end else if (pend_s[3]) begin
            int_id_s = 5'd3;
        end else if (pend_s[7]) begin
            int_id_s = 5'd7;
        end else begin
            int_id_s = 5'd0;
        end
    end

    // Interrupt target: vectored mode offsets the base by 4*id
    always_comb begin
        int_target_s = mtvec_base_s;
        if (mtvec_r[0]) begin
            int_target_s = mtvec_base_s + {25'd0, int_id_s, 2'b00};
        end else begin
            int_target_s = mtvec_base_s;
        end
    end

    // Map the pipeline's compact cause encoding onto mcause exception codes
    always_comb begin
        exc_code_s = 4'd2;
        case (exception_cause_i)
            EXCEP_INSTR_MISALIGNED:        exc_code_s = 4'd0;
            EXCEP_ILLEGAL_INSTRUCTION:     exc_code_s = 4'd2;
            EXCEP_BREAKPOINT:              exc_code_s = 4'd3;
            EXCEP_LOAD_ADRESS_MISALIGNED:  exc_code_s = 4'd4;
            EXCEP_STORE_ADRESS_MISALIGNED: exc_code_s = 4'd6;
            EXCEP_ENV_CALL:                exc_code_s = 4'd11;
            default:                       exc_code_s = 4'd2;
        endcase
    end

    // CSR read decode
    always_comb begin
        csr_rdata_o = 32'd0;
        case (csr_addr_i)
            CSR_MSTATUS: csr_rdata_o = mstatus_s;
            CSR_MIE:     csr_rdata_o = mie_csr_r;
            CSR_MTVEC:   csr_rdata_o = mtvec_r;
            CSR_MEPC:    csr_rdata_o = mepc_r;
            CSR_MCAUSE:  csr_rdata_o = mcause_r;
            CSR_MTVAL:   csr_rdata_o = mtval_r;
            CSR_MIP:     csr_rdata_o = mip_s;
            default:     csr_rdata_o = 32'd0;
        endcase
    end

    // Trap sequencer and CSR state. CSR writes are applied first so that a
    // trap update in the same cycle overrides them (last assignment wins).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r          <= ST_IDLE;
            mstatus_mie_r    <= 1'b0;
            mstatus_mpie_r   <= 1'b0;
            mie_csr_r        <= 32'd0;
            mtvec_r          <= RESET_MTVEC;
            mepc_r           <= 32'd0;
            mcause_r         <= 32'd0;
            mtval_r          <= 32'd0;
            target_r         <= 32'd0;
            redirect_valid_r <= 1'b0;
            flush_all_r      <= 1'b0;
            trap_busy_r      <= 1'b0;
        end else begin
            if (csr_we_i) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_r  <= csr_wdata_i[3];
                        mstatus_mpie_r <= csr_wdata_i[7];
                    end
                    CSR_MIE:    mie_csr_r <= csr_wdata_i & MIE_MASK;
                    // Reserved modes 2/3 collapse to direct mode
                    CSR_MTVEC:  mtvec_r   <= {csr_wdata_i[31:2], 1'b0,
                                              (csr_wdata_i[1] ? 1'b0 : csr_wdata_i[0])};
                    CSR_MEPC:   mepc_r    <= csr_wdata_i & ~32'd1;
                    CSR_MCAUSE: mcause_r  <= csr_wdata_i;
                    CSR_MTVAL:  mtval_r   <= csr_wdata_i;
                    default: begin
                    end
                endcase
            end

            case (state_r)
                ST_IDLE: begin
                    if (en_exception_i) begin
                        mepc_r           <= exception_program_counter_i & ~32'd1;
                        mtval_r          <= exception_adress_i;
                        mcause_r         <= {28'd0, exc_code_s};
                        mstatus_mpie_r   <= mstatus_mie_r;
                        mstatus_mie_r    <= 1'b0;
                        target_r         <= mtvec_base_s;
                        state_r          <= ST_REDIRECT;
                        redirect_valid_r <= 1'b1;
                        flush_all_r      <= 1'b1;
                        trap_busy_r      <= 1'b1;
                    end else if (mret_i) begin
                        // mepc_r is the pre-write value even if software
                        // writes mepc in this same cycle
                        mstatus_mie_r    <= mstatus_mpie_r;
                        mstatus_mpie_r   <= 1'b1;
                        target_r         <= mepc_r;
                        state_r          <= ST_REDIRECT;
                        redirect_valid_r <= 1'b1;
                        flush_all_r      <= 1'b1;
                        trap_busy_r      <= 1'b1;
                    end else if (int_take_s) begin
                        mepc_r           <= interrupt_pc_i;
                        mcause_r         <= {1'b1, 26'd0, int_id_s};
                        mtval_r          <= 32'd0;
                        mstatus_mpie_r   <= mstatus_mie_r;
                        mstatus_mie_r    <= 1'b0;
                        target_r         <= int_target_s;
                        state_r          <= ST_REDIRECT;
                        redirect_valid_r <= 1'b1;
                        flush_all_r      <= 1'b1;
                        trap_busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_valid_r && redirect_ready_i) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                        flush_all_r      <= 1'b0;
                        trap_busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_REDIRECT;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    redirect_valid_r <= 1'b0;
                    flush_all_r      <= 1'b0;
                    trap_busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = target_r;
    assign flush_all_o      = flush_all_r;
    assign trap_busy_o      = trap_busy_r;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: CSR and exception vector tables
// plus hand-written sequences for handshake hold, interrupts, mret and reset.
module tb_trap_controller;

    localparam logic [31:0] RST_MTVEC = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_exception_i;
    logic [2:0]  exception_cause_i;
    logic [31:0] exception_program_counter_i;
    logic [31:0] exception_adress_i;
    logic        mret_i;
    logic [31:0] interrupt_pc_i;
    logic        interrupt_accept_i;
    logic        irq_software_i;
    logic        irq_timer_i;
    logic        irq_external_i;
    logic [11:0] csr_addr_i;
    logic        csr_we_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        flush_all_o;
    logic        trap_busy_o;

    trap_controller #(.RESET_MTVEC(RST_MTVEC), .XLEN(32)) dut (
        .clk_i                       (clk_i),
        .rst_ni                      (rst_ni),
        .en_exception_i              (en_exception_i),
        .exception_cause_i           (exception_cause_i),
        .exception_program_counter_i (exception_program_counter_i),
        .exception_adress_i          (exception_adress_i),
        .mret_i                      (mret_i),
        .interrupt_pc_i              (interrupt_pc_i),
        .interrupt_accept_i          (interrupt_accept_i),
        .irq_software_i              (irq_software_i),
        .irq_timer_i                 (irq_timer_i),
        .irq_external_i              (irq_external_i),
        .csr_addr_i                  (csr_addr_i),
        .csr_we_i                    (csr_we_i),
        .csr_wdata_i                 (csr_wdata_i),
        .csr_rdata_o                 (csr_rdata_o),
        .redirect_valid_o            (redirect_valid_o),
        .redirect_pc_o               (redirect_pc_o),
        .redirect_ready_i            (redirect_ready_i),
        .flush_all_o                 (flush_all_o),
        .trap_busy_o                 (trap_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    typedef struct {
        logic [2:0]  cause;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] exp_mcause;
        logic [31:0] exp_mepc;
    } exc_vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    csr_vec_t    csr_tab[12];
    exc_vec_t    exc_tab[6];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i = a;
        #1;
        check(name, csr_rdata_o, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr_i  = a;
        csr_wdata_i = d;
        csr_we_i    = 1'b1;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic drive_exc(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] ad,
                             input logic [31:0] exp_target);
        exp_q.push_back(exp_target);
        en_exception_i              = 1'b1;
        exception_cause_i           = c;
        exception_program_counter_i = pc;
        exception_adress_i          = ad;
        tick();
        en_exception_i              = 1'b0;
    endtask

    // Waits (bounded) for the redirect, then compares it with the scoreboard
    task automatic check_redirect(input string name);
        int w = 0;
        while (redirect_valid_o !== 1'b1 && w < 8) begin
            tick();
            w++;
        end
        check({name, " latency"}, w, 32'd0);
        check({name, " flush"}, {31'd0, flush_all_o}, 32'd1);
        check({name, " busy"}, {31'd0, trap_busy_o}, 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got pc %h", name, redirect_pc_o);
        end else begin
            check({name, " pc"}, redirect_pc_o, exp_q.pop_front());
        end
    endtask

    task automatic accept(input string name);
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        check({name, " valid drop"}, {31'd0, redirect_valid_o}, 32'd0);
        check({name, " flush drop"}, {31'd0, flush_all_o}, 32'd0);
    endtask

    initial begin
        int  cnt;
        logic seen;

        csr_tab[0]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
        csr_tab[1]  = '{12'h300, 32'h0000_0000, 32'h0000_1800};
        csr_tab[2]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
        csr_tab[3]  = '{12'h304, 32'h0000_0000, 32'h0000_0000};
        csr_tab[4]  = '{12'h305, 32'h0000_0103, 32'h0000_0100};
        csr_tab[5]  = '{12'h305, 32'h0000_0201, 32'h0000_0201};
        csr_tab[6]  = '{12'h305, 32'h0000_0102, 32'h0000_0100};
        csr_tab[7]  = '{12'h341, 32'h0000_2001, 32'h0000_2000};
        csr_tab[8]  = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        csr_tab[9]  = '{12'h343, 32'h1234_5678, 32'h1234_5678};
        csr_tab[10] = '{12'h344, 32'h0000_FFFF, 32'h0000_0000};
        csr_tab[11] = '{12'h7C0, 32'h0000_0055, 32'h0000_0000};

        exc_tab[0] = '{3'd0, 32'h0000_1000, 32'h0000_0000, 32'd0,  32'h0000_1000};
        exc_tab[1] = '{3'd1, 32'h0000_2000, 32'h0000_0000, 32'd2,  32'h0000_2000};
        exc_tab[2] = '{3'd2, 32'h0000_2005, 32'h0000_0000, 32'd3,  32'h0000_2004};
        exc_tab[3] = '{3'd3, 32'h0000_0040, 32'h0000_1003, 32'd4,  32'h0000_0040};
        exc_tab[4] = '{3'd4, 32'h0000_0080, 32'h0000_2002, 32'd6,  32'h0000_0080};
        exc_tab[5] = '{3'd5, 32'hABCD_0003, 32'h0000_0000, 32'd11, 32'hABCD_0002};

        rst_ni = 1'b0; en_exception_i = 1'b0; exception_cause_i = 3'd0;
        exception_program_counter_i = 32'd0; exception_adress_i = 32'd0;
        mret_i = 1'b0; interrupt_pc_i = 32'd0; interrupt_accept_i = 1'b0;
        irq_software_i = 1'b0; irq_timer_i = 1'b0; irq_external_i = 1'b0;
        csr_addr_i = 12'h000; csr_we_i = 1'b0; csr_wdata_i = 32'd0;
        redirect_ready_i = 1'b0;

        // Reset state
        #12;
        check("rst valid", {31'd0, redirect_valid_o}, 32'd0);
        check("rst busy", {31'd0, trap_busy_o}, 32'd0);
        check_csr("rst mtvec", 12'h305, RST_MTVEC);
        check_csr("rst mstatus", 12'h300, 32'h0000_1800);
        check_csr("rst mepc", 12'h341, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // CSR write/read table
        for (int i = 0; i < 12; i++) begin
            csr_wr(csr_tab[i].addr, csr_tab[i].wdata);
            check_csr($sformatf("csr[%0d]", i), csr_tab[i].addr, csr_tab[i].exp);
            tick();
        end

        // Exception table, mtvec = 0x100 direct
        for (int i = 0; i < 6; i++) begin
            drive_exc(exc_tab[i].cause, exc_tab[i].pc, exc_tab[i].addr, 32'h0000_0100);
            check_redirect($sformatf("exc[%0d]", i));
            accept($sformatf("exc[%0d]", i));
            check_csr($sformatf("exc[%0d] mcause", i), 12'h342, exc_tab[i].exp_mcause);
            check_csr($sformatf("exc[%0d] mepc", i), 12'h341, exc_tab[i].exp_mepc);
            check_csr($sformatf("exc[%0d] mtval", i), 12'h343, exc_tab[i].addr);
            tick();
        end

        // Load misaligned with ready held low; a second exception is ignored
        drive_exc(3'd3, 32'h0000_0040, 32'h0000_1003, 32'h0000_0100);
        check_redirect("hold");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (redirect_valid_o !== 1'b1) break;
            cnt++;
            redirect_ready_i            = (cnt >= 4);
            en_exception_i              = (cnt == 2 || cnt == 3);
            exception_cause_i           = 3'd5;
            exception_program_counter_i = 32'h0000_0999;
            exception_adress_i          = 32'h0000_0777;
            tick();
        end
        redirect_ready_i = 1'b0;
        en_exception_i   = 1'b0;
        check("hold cycles", cnt, 32'd4);
        check("hold valid after", {31'd0, redirect_valid_o}, 32'd0);
        check_csr("hold mcause", 12'h342, 32'd4);
        check_csr("hold mtval", 12'h343, 32'h0000_1003);
        check_csr("hold mepc", 12'h341, 32'h0000_0040);
        tick();

        // Vectored interrupt: external beats timer
        csr_wr(12'h305, 32'h0000_0201);
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0880);
        irq_timer_i = 1'b1; irq_external_i = 1'b1;
        interrupt_accept_i = 1'b1; interrupt_pc_i = 32'h0000_3000;
        exp_q.push_back(32'h0000_022C);
        tick();
        interrupt_accept_i = 1'b0; irq_timer_i = 1'b0; irq_external_i = 1'b0;
        check_redirect("virq");
        check_csr("virq mcause", 12'h342, 32'h8000_000B);
        check_csr("virq mstatus", 12'h300, 32'h0000_1880);
        check_csr("virq mepc", 12'h341, 32'h0000_3000);
        check_csr("virq mtval", 12'h343, 32'd0);
        accept("virq");

        // mret with same-cycle mepc write: target uses the old mepc
        csr_addr_i = 12'h341; csr_wdata_i = 32'h0000_5000; csr_we_i = 1'b1;
        mret_i = 1'b1;
        exp_q.push_back(32'h0000_3000);
        tick();
        mret_i = 1'b0; csr_we_i = 1'b0;
        check_redirect("mret");
        check_csr("mret mstatus", 12'h300, 32'h0000_1888);
        check_csr("mret mepc", 12'h341, 32'h0000_5000);
        accept("mret");

        // Exception beats mret; same-cycle mcause write is dropped
        csr_addr_i = 12'h342; csr_wdata_i = 32'h0000_0077; csr_we_i = 1'b1;
        mret_i = 1'b1;
        drive_exc(3'd2, 32'h0000_4001, 32'h0000_0000, 32'h0000_0200);
        mret_i = 1'b0; csr_we_i = 1'b0;
        check_redirect("exc+mret");
        check_csr("exc+mret mepc", 12'h341, 32'h0000_4000);
        check_csr("exc+mret mcause", 12'h342, 32'd3);
        check_csr("exc+mret mstatus", 12'h300, 32'h0000_1880);
        accept("exc+mret");

        // Software beats timer, vectored offset 4*3
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0088);
        irq_software_i = 1'b1; irq_timer_i = 1'b1;
        interrupt_accept_i = 1'b1; interrupt_pc_i = 32'h0000_6000;
        exp_q.push_back(32'h0000_020C);
        tick();
        interrupt_accept_i = 1'b0; irq_software_i = 1'b0; irq_timer_i = 1'b0;
        check_redirect("sirq");
        check_csr("sirq mcause", 12'h342, 32'h8000_0003);
        accept("sirq");

        // Masking: MIE=0, then interrupt_accept_i=0
        irq_timer_i = 1'b1; interrupt_accept_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (redirect_valid_o) seen = 1'b1;
        end
        check("mask mie0", {31'd0, seen}, 32'd0);
        check_csr("mask mip", 12'h344, 32'h0000_0080);
        interrupt_accept_i = 1'b0;
        csr_wr(12'h300, 32'h0000_0008);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (redirect_valid_o) seen = 1'b1;
        end
        check("mask accept0", {31'd0, seen}, 32'd0);
        irq_timer_i = 1'b0;
        csr_wr(12'h300, 32'h0000_0000);

        // Reset asserted mid-redirect
        drive_exc(3'd5, 32'h0000_0600, 32'h0000_0000, 32'h0000_0200);
        check_redirect("rstmid");
        #2;
        rst_ni = 1'b0;
        #1;
        check("rstmid valid", {31'd0, redirect_valid_o}, 32'd0);
        check("rstmid busy", {31'd0, trap_busy_o}, 32'd0);
        check_csr("rstmid mtvec", 12'h305, RST_MTVEC);
        check_csr("rstmid mepc", 12'h341, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("rstmid after", {31'd0, redirect_valid_o}, 32'd0);
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer that sits between pipeline_controller and the fetch stage.
- Consumes the prioritised exception report (en_exception, cause, PC, address), machine interrupt lines and the mret signal.
- Owns the trap CSRs: mstatus, mie, mip, mtvec, mepc, mcause, mtval.
- Drives a PC redirect plus full-pipeline flush through a ready/valid handshake with fetch.

Parameters:
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset.
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_exception_i  in  1  exception reported this cycle.
- exception_cause_i  in  3  `EXCEP_* code.
- exception_program_counter_i  in  32  faulting instruction PC.
- exception_adress_i  in  32  faulting data address; 0 for non-address exceptions.
- mret_i  in  1  mret retiring this cycle.
- interrupt_pc_i  in  32  PC of the next unretired instruction, used as mepc for interrupts.
- interrupt_accept_i  in  1  pipeline is at an instruction boundary where an interrupt may be taken.
- irq_software_i, irq_timer_i, irq_external_i  in  1 each  level-sensitive pending lines.
- csr_addr_i  in  12  CSR address.
- csr_we_i  in  1  CSR write enable.
- csr_wdata_i  in  32  CSR write data.
- csr_rdata_o  out  32  combinational read data for csr_addr_i.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_pc_o  out  32  redirect target.
- redirect_ready_i  in  1  fetch accepts the redirect.
- flush_all_o  out  1  flush fetch, decode and execute.
- trap_busy_o  out  1  controller is not IDLE; upstream holds new exceptions.

Behaviour:
- Reset (async, rst_ni low):
  - State IDLE; mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mtval=0; mtvec=RESET_MTVEC.
  - All outputs 0 except csr_rdata_o, which follows the decode of reset values.
- States: IDLE, REDIRECT.
- IDLE, per rising edge, priority exception > mret > interrupt:
  - Exception (en_exception_i):
    - mepc = exception_program_counter_i with bit0 cleared; mtval = exception_adress_i.
    - mcause = {1'b0, 27'b0, code}. Code mapping: INSTR_MISALIGNED→0, ILLEGAL_INSTRUCTION→2, BREAKPOINT→3, LOAD_ADRESS_MISALIGNED→4, STORE_ADRESS_MISALIGNED→6, ENV_CALL→11.
    - MPIE=MIE, MIE=0.
    - target = {mtvec[31:2], 2'b00}; go to REDIRECT.
  - mret (mret_i): MIE=MPIE, MPIE=1; target = mepc; go to REDIRECT.
  - Interrupt (interrupt_accept_i & mstatus.MIE & |(mip & mie)):
    - Select highest pending: external (11) > software (3) > timer (7).
    - mepc = interrupt_pc_i; mcause = {1'b1, 26'b0, id}; mtval = 0; MPIE=MIE, MIE=0.
    - target = base if mtvec[1:0]==0; base + 4*id if mtvec[1:0]==1.
    - Go to REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, redirect_pc_o=target, flush_all_o=1, trap_busy_o=1; all three registered and stable until handshake.
  - redirect_valid_o & redirect_ready_i → IDLE next edge.
  - en_exception_i, mret_i and interrupts are ignored while in REDIRECT.
- Latency: event at edge N → redirect_valid_o high from N to acceptance; minimum one cycle.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 MPP read 2'b11, other bits read 0.
  - mie 0x304: bits 3/7/11 writable.
  - mtvec 0x305: bits[1:0]=2 or 3 stored as 0.
  - mepc 0x341: bit0 forced 0.
  - mcause 0x342, mtval 0x343: full width.
  - mip 0x344: read-only, bit3 = irq_software_i, bit7 = irq_timer_i, bit11 = irq_external_i.
  - Unmapped addresses read 0, writes ignored.
- CSR writes are applied at the clock edge.
- Same-cycle trap entry and csr_we_i to the same CSR: the trap update wins and the CSR write is dropped.
- mret in the same cycle as a CSR write to mepc: target uses the old mepc.
- Reset asserted in REDIRECT: immediate return to IDLE; redirect_valid_o drops asynchronously.

Test Plan:
- Illegal instruction: mtvec=0x100, exception (cause ILLEGAL, pc 0x2000, addr 0) → mepc=0x2000, mcause=2, mtval=0, redirect_pc_o=0x100 one cycle later, flush_all_o high until ready.
- Load misaligned: pc 0x40, addr 0x1003, redirect_ready_i low 3 cycles → mcause=4, mtval=0x1003; redirect_valid_o held for 4 cycles; second exception during the hold ignored.
- Vectored interrupt: mtvec=0x201, MIE=1, mie=0x880, timer+external pending, interrupt_accept_i=1, interrupt_pc_i=0x3000 → mcause=0x8000000B, redirect_pc_o=0x22C, MIE=0, MPIE=1.
- mret: mepc=0x3000, MPIE=1 → redirect_pc_o=0x3000, MIE=1, MPIE=1; simultaneous exception → exception taken, mret dropped.
- Interrupt masking: irq_timer_i=1 with MIE=0, or with interrupt_accept_i=0 → no redirect; mip reads 0x80.
- Reset mid-REDIRECT: rst_ni low → redirect_valid_o=0 immediately, mtvec=RESET_MTVEC, mepc=0.
